// File: rtl/spi_coord_receiver.sv
// SPI mode-0 slave that receives 16-bit words and unpacks X/Y coordinate pairs.
// Inputs are synchronized into clk. Errors and valid outputs are one-cycle pulses.
module spi_coord_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic [9:0] x_out,
  output logic [8:0] y_out,
  output logic       coord_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic {WAIT_X, WAIT_Y} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [15:0]            shift_q, shift_d;
  logic [4:0]             cnt_q, cnt_d;
  state_t                 state_q, state_d;
  logic [9:0]             pend_x_q, pend_x_d;
  logic [9:0]             x_q, x_d;
  logic [8:0]             y_q, y_d;
  logic                   coord_valid_q, coord_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;

  logic        sclk_s, cs_s, mosi_s;
  logic        word_done, cs_abort, is_x, is_y;
  logic [15:0] word;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign word   = {shift_q[14:0], mosi_s};
  assign is_x   = word[15] && (word[14:10] == 5'd0);
  assign is_y   = !word[15] && (word[14:9] == 6'd0);

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    busy_d      = ~cs_s;
  end

  // Bit receiver: word_done fires combinationally on the 16th sampled bit.
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    cs_abort  = 1'b0;
    if (cs_s) begin
      cnt_d   = 5'd0;
      shift_d = 16'd0;
      if (!cs_prev_q && (cnt_q != 5'd0)) begin
        cs_abort = 1'b1;
      end
    end else if (sclk_s && !sclk_prev_q) begin
      shift_d = word;
      if (cnt_q == 5'd15) begin
        word_done = 1'b1;
        cnt_d     = 5'd0;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  // Unpacker: pairs an X word with the following Y word.
  always_comb begin
    state_d       = state_q;
    pend_x_d      = pend_x_q;
    x_d           = x_q;
    y_d           = y_q;
    coord_valid_d = 1'b0;
    frame_err_d   = cs_abort;
    if (word_done) begin
      case (state_q)
        WAIT_X: begin
          if (is_x) begin
            pend_x_d = word[9:0];
            state_d  = WAIT_Y;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        WAIT_Y: begin
          if (is_y) begin
            x_d           = pend_x_q;
            y_d           = word[8:0];
            coord_valid_d = 1'b1;
            state_d       = WAIT_X;
          end else if (is_x) begin
            frame_err_d = 1'b1;
            pend_x_d    = word[9:0];
          end else begin
            frame_err_d = 1'b1;
            pend_x_d    = 10'd0;
            state_d     = WAIT_X;
          end
        end
        default: state_d = WAIT_X;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q   <= '0;
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      cs_prev_q     <= 1'b1;
      shift_q       <= 16'd0;
      cnt_q         <= 5'd0;
      state_q       <= WAIT_X;
      pend_x_q      <= 10'd0;
      x_q           <= 10'd0;
      y_q           <= 9'd0;
      coord_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      cs_prev_q     <= cs_prev_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      pend_x_q      <= pend_x_d;
      x_q           <= x_d;
      y_q           <= y_d;
      coord_valid_q <= coord_valid_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
    end
  end

  assign x_out       = x_q;
  assign y_out       = y_q;
  assign coord_valid = coord_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_coord_receiver.sv
// Directed bench for spi_coord_receiver: drives SPI frames and checks the
// coordinate outputs and the pulse counts observed between steps.
module tb_spi_coord_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic [9:0] x_out;
  logic [8:0] y_out;
  logic       coord_valid;
  logic       frame_err;
  logic       busy;

  int tests  = 0;
  int failed = 0;

  int cv_cnt = 0, fe_cnt = 0, both_cnt = 0, bad_chg = 0;
  int cv_base, fe_base;
  logic [9:0] prev_x;
  logic [8:0] prev_y;

  spi_coord_receiver #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .x_out(x_out), .y_out(y_out), .coord_valid(coord_valid),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters and output-stability watch, sampled on the falling edge.
  always @(negedge clk) begin
    if (coord_valid === 1'b1) cv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
    if (coord_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    if (reset === 1'b0 && coord_valid !== 1'b1 && (x_out !== prev_x || y_out !== prev_y))
      bad_chg++;
    prev_x = x_out;
    prev_y = y_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 15; i > 15 - n; i--) begin
      mosi = w[i];
      #50 sclk = 1'b1;
      #50 sclk = 1'b0;
    end
  endtask

  task automatic mark();
    cv_base = cv_cnt;
    fe_base = fe_cnt;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    #50;
  endtask

  task automatic cs_high();
    #50 cs_n = 1'b1;
    #100;
  endtask

  initial begin
    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    #12;
    check("rst_x", 32'(x_out), 32'h0);
    check("rst_y", 32'(y_out), 32'h0);
    check("rst_cv", 32'(coord_valid), 32'h0);
    check("rst_fe", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    #18 reset = 1'b0;
    #40;

    // Basic pair in one frame
    mark();
    cs_low();
    check("busy_hi", 32'(busy), 32'h1);
    send_bits(16'h82A5, 16);
    send_bits(16'h01F0, 16);
    cs_high();
    check("t1_cv", 32'(cv_cnt - cv_base), 32'd1);
    check("t1_fe", 32'(fe_cnt - fe_base), 32'd0);
    check("t1_x", 32'(x_out), 32'h2A5);
    check("t1_y", 32'(y_out), 32'h1F0);
    check("busy_lo", 32'(busy), 32'h0);

    // Y word while waiting for X
    mark();
    cs_low(); send_bits(16'h01F0, 16); cs_high();
    check("t2_fe", 32'(fe_cnt - fe_base), 32'd1);
    check("t2_cv", 32'(cv_cnt - cv_base), 32'd0);
    check("t2_x", 32'(x_out), 32'h2A5);
    check("t2_y", 32'(y_out), 32'h1F0);

    // X replaced by a second X
    mark();
    cs_low();
    send_bits(16'h8001, 16); #50;
    check("t3_fe_w1", 32'(fe_cnt - fe_base), 32'd0);
    send_bits(16'h8002, 16); #50;
    check("t3_fe_w2", 32'(fe_cnt - fe_base), 32'd1);
    send_bits(16'h0003, 16);
    cs_high();
    check("t3_cv", 32'(cv_cnt - cv_base), 32'd1);
    check("t3_x", 32'(x_out), 32'h002);
    check("t3_y", 32'(y_out), 32'h003);

    // Reserved bit set: error, FSM stays WAIT_X so a Y word errors too
    mark();
    cs_low(); send_bits(16'h86A5, 16); cs_high();
    check("t4_fe_rsv", 32'(fe_cnt - fe_base), 32'd1);
    mark();
    cs_low(); send_bits(16'h0003, 16); cs_high();
    check("t4_fe_y", 32'(fe_cnt - fe_base), 32'd1);
    check("t4_cv_y", 32'(cv_cnt - cv_base), 32'd0);

    // Malformed word in WAIT_Y discards pending X
    mark();
    cs_low();
    send_bits(16'h8010, 16); #50;
    check("t5_fe_w1", 32'(fe_cnt - fe_base), 32'd0);
    send_bits(16'h0A00, 16);
    cs_high();
    check("t5_fe_w2", 32'(fe_cnt - fe_base), 32'd1);
    mark();
    cs_low(); send_bits(16'h0001, 16); cs_high();
    check("t5_fe_y", 32'(fe_cnt - fe_base), 32'd1);
    check("t5_cv_y", 32'(cv_cnt - cv_base), 32'd0);
    check("t5_x", 32'(x_out), 32'h002);
    check("t5_y", 32'(y_out), 32'h003);

    // Truncated frame, then max-value pair
    mark();
    cs_low(); send_bits(16'hFFFF, 8); cs_high();
    check("t6_fe_trunc", 32'(fe_cnt - fe_base), 32'd1);
    mark();
    cs_low(); send_bits(16'h83FF, 16); send_bits(16'h01FF, 16); cs_high();
    check("t6_cv", 32'(cv_cnt - cv_base), 32'd1);
    check("t6_fe", 32'(fe_cnt - fe_base), 32'd0);
    check("t6_x", 32'(x_out), 32'h3FF);
    check("t6_y", 32'(y_out), 32'h1FF);

    // X/Y split across frames
    mark();
    cs_low(); send_bits(16'h8155, 16); cs_high();
    cs_low(); send_bits(16'h00AA, 16); cs_high();
    check("t7_cv", 32'(cv_cnt - cv_base), 32'd1);
    check("t7_x", 32'(x_out), 32'h155);
    check("t7_y", 32'(y_out), 32'h0AA);

    // Reset mid-word
    mark();
    cs_low(); send_bits(16'h8123, 9);
    #20 reset = 1'b1;
    #20;
    check("t8_rst_x", 32'(x_out), 32'h0);
    check("t8_rst_y", 32'(y_out), 32'h0);
    check("t8_rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    #100;
    cs_high();
    check("t8_fe", 32'(fe_cnt - fe_base), 32'd0);
    mark();
    cs_low(); send_bits(16'h8123, 16); send_bits(16'h0045, 16); cs_high();
    check("t8_cv", 32'(cv_cnt - cv_base), 32'd1);
    check("t8_fe2", 32'(fe_cnt - fe_base), 32'd0);
    check("t8_x", 32'(x_out), 32'h123);
    check("t8_y", 32'(y_out), 32'h045);

    check("never_both", 32'(both_cnt), 32'd0);
    check("xy_stable", 32'(bad_chg), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/spi_coord_receiver.md
SPI_COORD_RECEIVER -- requirements
Module: spi_coord_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on each of sclk, cs_n and mosi (minimum 2).
REQ-002 SHALL have port clk, input, 1: system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port sclk, input, 1: SPI serial clock from the master, asynchronous to clk.
REQ-005 SHALL have port cs_n, input, 1: SPI chip select, active-low, asynchronous to clk.
REQ-006 SHALL have port mosi, input, 1: SPI serial data, MSB first.
REQ-007 SHALL have port x_out, output, 10: last accepted X coordinate.
REQ-008 SHALL have port y_out, output, 9: last accepted Y coordinate.
REQ-009 SHALL have port coord_valid, output, 1: one-clk pulse; x_out/y_out were updated as a pair.
REQ-010 SHALL have port frame_err, output, 1: one-clk pulse on any protocol violation.
REQ-011 SHALL have port busy, output, 1: high while synchronized cs_n is low.

Function
REQ-012 SHALL pass sclk, cs_n and mosi through SYNC_STAGES flops; all later logic uses only synchronized copies.
REQ-013 SHALL support SPI mode 0 only: mosi sampled on a synchronized sclk rising edge (current 1, previous 0) while synchronized cs_n is low; sclk period >= 8 clk periods.
REQ-014 SHALL shift sampled bits into a 16-bit shift register MSB first, with a 5-bit bit counter counting 0..16.
REQ-015 SHALL, on the 16th bit, assert internal word_done for one clk, reset the counter to 0, and keep receiving further words back-to-back within the same cs_n assertion.
REQ-016 SHALL, on a synchronized cs_n rising edge with counter not 0, pulse frame_err, discard the partial word, and clear the counter; unpacker state is unchanged.
REQ-017 SHALL hold the counter at 0 and ignore sclk edges while synchronized cs_n is high.
REQ-018 SHALL classify a complete word W: X-word if W[15]=1 and W[14:10]=0; Y-word if W[15]=0 and W[14:9]=0; otherwise malformed.
REQ-019 SHALL implement the unpacker FSM with states WAIT_X and WAIT_Y; reset state WAIT_X.
REQ-020 WAIT_X: X-word -> store W[9:0] in a pending-X register, go to WAIT_Y; Y-word -> frame_err pulse, stay WAIT_X; malformed -> frame_err pulse, stay WAIT_X.
REQ-021 WAIT_Y: Y-word -> x_out <= pending X, y_out <= W[8:0], coord_valid pulse, go to WAIT_X.
REQ-022 WAIT_Y: X-word -> frame_err pulse, replace pending X with the new W[9:0], stay WAIT_Y.
REQ-023 WAIT_Y: malformed -> frame_err pulse, discard pending X, go to WAIT_X.
REQ-024 SHALL retain pending X and FSM state across cs_n deassertion (X and Y may arrive in separate chip-select frames).
REQ-025 coord_valid and frame_err SHALL be registered and assert in the clk cycle after word_done (or after the cs_n rising edge for REQ-016); they are never asserted in the same cycle.
REQ-026 x_out and y_out SHALL change only in the cycle coord_valid is asserted and hold otherwise.
REQ-027 SHALL update busy one clk after synchronized cs_n changes.

Reset
REQ-028 On reset: x_out=0, y_out=0, coord_valid=0, frame_err=0, busy=0, shift register=0, counter=0, pending X=0, FSM=WAIT_X, synchronizer flops set to idle (sclk=0, cs_n=1, mosi=0).
REQ-029 Reset asserted mid-word SHALL discard the partial word without a frame_err pulse; after release, the first word counts from bit 0 at the next cs_n low.

Verification
REQ-030 One cs_n frame carrying 0x82A5 then 0x01F0 -> single coord_valid pulse, x_out=0x2A5, y_out=0x1F0, frame_err never high.
REQ-031 0x01F0 sent while in WAIT_X -> frame_err pulse, no coord_valid, x_out/y_out unchanged.
REQ-032 0x8001, 0x8002, 0x0003 -> frame_err pulse on the second word, then coord_valid with x_out=0x002, y_out=0x003.
REQ-033 0x86A5 (reserved bit set) -> frame_err pulse, FSM stays WAIT_X; 0x8010 then 0x0A00 -> frame_err on the second word, FSM returns to WAIT_X.
REQ-034 8 bits clocked then cs_n high -> frame_err pulse; next frame 0x83FF, 0x01FF -> coord_valid, x_out=0x3FF, y_out=0x1FF.
REQ-035 reset pulsed after 9 bits of 0x8123 -> all outputs 0, no frame_err; full 0x8123, 0x0045 afterwards -> x_out=0x123, y_out=0x045.
